// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_uart_tx                                                  |
// | Function : Pops FIFO words when idle and sends each as 8N1 UART bytes,   |
// |            most significant byte first, LSB first within a byte.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fifo_uart_tx #(
   parameter int width  = 16,
   parameter int clkdiv = 868,
   parameter int divsz  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [width-1:0] fifo_data,
   input  logic             fifo_empty,
   output logic             fifo_rd_done,
   output logic             txd,
   output logic             busy
);

   localparam int c_nbytes = width / 8;
   localparam int c_bw     = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;

   localparam logic [c_bw-1:0]  c_last_byte = c_bw'(c_nbytes - 1);
   localparam logic [c_bw-1:0]  c_byte_one  = c_bw'(1);
   localparam logic [divsz-1:0] c_div_last  = divsz'(clkdiv - 1);
   localparam logic [divsz-1:0] c_div_one   = divsz'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t           r_state, w_state;
   logic [divsz-1:0] r_div, w_div;
   logic [2:0]       r_bit, w_bit;
   logic [c_bw-1:0]  r_byte, w_byte;
   logic [width-1:0] r_shift, w_shift;
   logic             r_txd, w_txd;
   logic             r_rd_done, w_rd_done;
   logic             w_bit_end;
   logic [7:0]       w_cur_byte;

   // The byte on the wire always sits in the top 8 bits; the word shifts up per byte.
   assign w_cur_byte = r_shift[width-1 -: 8];
   assign w_bit_end  = (r_div == c_div_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_bit     <= '0;
         r_byte    <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
         r_rd_done <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_div     <= w_div;
         r_bit     <= w_bit;
         r_byte    <= w_byte;
         r_shift   <= w_shift;
         r_txd     <= w_txd;
         r_rd_done <= w_rd_done;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_div     = r_div;
      w_bit     = r_bit;
      w_byte    = r_byte;
      w_shift   = r_shift;
      w_txd     = r_txd;
      w_rd_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_txd = 1'b1;
            if (!fifo_empty) begin
               w_shift   = fifo_data;
               w_byte    = '0;
               w_bit     = '0;
               w_div     = '0;
               w_state   = S_START;
               w_txd     = 1'b0;
               w_rd_done = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_div   = '0;
               w_bit   = '0;
               w_state = S_DATA;
               w_txd   = w_cur_byte[0];
            end else begin
               w_div = r_div + c_div_one;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_div = '0;
               if (r_bit == 3'd7) begin
                  w_state = S_STOP;
                  w_txd   = 1'b1;
               end else begin
                  w_bit = r_bit + 3'd1;
                  w_txd = w_cur_byte[w_bit];
               end
            end else begin
               w_div = r_div + c_div_one;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_div = '0;
               if (r_byte != c_last_byte) begin
                  w_byte  = r_byte + c_byte_one;
                  w_shift = r_shift << 8;
                  w_state = S_START;
                  w_txd   = 1'b0;
               end else begin
                  w_state = S_IDLE;
                  w_txd   = 1'b1;
               end
            end else begin
               w_div = r_div + c_div_one;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_txd   = 1'b1;
         end
      endcase
   end

   assign txd          = r_txd;
   assign fifo_rd_done = r_rd_done;
   assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire
